mem_port_arbiter: RTL and testbench

- Shares the single unified memory port between instruction fetch (I side) and load/store data access (D side).
- Accepts one request per side through a ready/valid handshake and keeps one transaction outstanding on the memory bus.
- Routes the response back to the side that issued the request.
- D side has priority; a bounded-streak rule keeps instruction fetch from starving.

---
 rtl/mem_port_arbiter_if.sv | 50 +++++
 rtl/mem_port_arbiter.sv | 150 +++++++++++++++
 tb/tb_mem_port_arbiter.sv | 270 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_if.sv
// Bundles the fetch (I), load/store (D) and memory-side signals of the
// unified memory port arbiter.
//   i_*  : instruction fetch request/response
//   d_*  : load/store request/response
//   m_*  : single outstanding memory bus transaction
// slave modport is the arbiter's view; master modport is the environment's view
// (requesters plus memory).
interface mem_port_arbiter_if;
    logic        i_req_i;
    logic [31:0] i_addr_i;
    logic        i_ready_o;
    logic        i_rvalid_o;
    logic [31:0] i_rdata_o;

    logic        d_req_i;
    logic        d_we_i;
    logic [31:0] d_addr_i;
    logic [31:0] d_wdata_i;
    logic [3:0]  d_wstrb_i;
    logic        d_ready_o;
    logic        d_rvalid_o;
    logic [31:0] d_rdata_o;

    logic        m_req_o;
    logic        m_we_o;
    logic [31:0] m_addr_o;
    logic [31:0] m_wdata_o;
    logic [3:0]  m_wstrb_o;
    logic        m_ready_i;
    logic        m_rvalid_i;
    logic [31:0] m_rdata_i;

    modport slave (
        input  i_req_i, i_addr_i,
        output i_ready_o, i_rvalid_o, i_rdata_o,
        input  d_req_i, d_we_i, d_addr_i, d_wdata_i, d_wstrb_i,
        output d_ready_o, d_rvalid_o, d_rdata_o,
        output m_req_o, m_we_o, m_addr_o, m_wdata_o, m_wstrb_o,
        input  m_ready_i, m_rvalid_i, m_rdata_i
    );

    modport master (
        output i_req_i, i_addr_i,
        input  i_ready_o, i_rvalid_o, i_rdata_o,
        output d_req_i, d_we_i, d_addr_i, d_wdata_i, d_wstrb_i,
        input  d_ready_o, d_rvalid_o, d_rdata_o,
        input  m_req_o, m_we_o, m_addr_o, m_wdata_o, m_wstrb_o,
        output m_ready_i, m_rvalid_i, m_rdata_i
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch (I) and load/store (D).
// One transaction outstanding at a time; D has priority, but after
// STARVE_LIMIT consecutive D grants with I waiting, I is forced through.
// Ports:
//   clk, reset   : clock, asynchronous active-low reset
//   bus          : I/D request/response and memory bus (slave modport)
//   busy_o       : registered, high whenever the FSM is not IDLE
//   spurious_o   : sticky flag, memory response seen outside RESP
// x_ready_o, x_rvalid_o and x_rdata_o are combinational; m_* are registered.
module mem_port_arbiter #(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic                clk,
    input  logic                reset,
    mem_port_arbiter_if.slave   bus,
    output logic                busy_o,
    output logic                spurious_o
);

    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam int unsigned SW = 4;
    localparam int unsigned CW = 4;

    localparam logic [CW-1:0] STREAK_MAX = '1;
    localparam logic [CW-1:0] LIMIT      = CW'(STARVE_LIMIT);
    localparam logic          OWNER_I    = 1'b0;
    localparam logic          OWNER_D    = 1'b1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t          state_q;
    state_t          state_d;
    logic            owner_q;
    logic [CW-1:0]   streak_q;
    logic            grant_i_c;
    logic            grant_d_c;
    logic            force_i_c;

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state, grant decision and combinational handshake outputs
    always_comb begin
        state_d        = state_q;
        grant_i_c      = 1'b0;
        grant_d_c      = 1'b0;
        force_i_c      = 1'b0;
        bus.i_ready_o  = 1'b0;
        bus.d_ready_o  = 1'b0;
        bus.i_rvalid_o = 1'b0;
        bus.d_rvalid_o = 1'b0;
        bus.i_rdata_o  = bus.m_rdata_i;
        bus.d_rdata_o  = bus.m_rdata_i;

        case (state_q)
            IDLE: begin
                // I overrides D once D has won LIMIT times in a row while I waited
                force_i_c = bus.i_req_i && (STARVE_LIMIT != 0) && (streak_q >= LIMIT);
                if (bus.d_req_i && !force_i_c) begin
                    grant_d_c = 1'b1;
                end else if (bus.i_req_i) begin
                    grant_i_c = 1'b1;
                end
                bus.i_ready_o = grant_i_c;
                bus.d_ready_o = grant_d_c;
                if (grant_i_c || grant_d_c) begin
                    state_d = REQ;
                end
            end
            REQ: begin
                if (bus.m_ready_i) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                if (bus.m_rvalid_i) begin
                    bus.i_rvalid_o = (owner_q == OWNER_I);
                    bus.d_rvalid_o = (owner_q == OWNER_D);
                    state_d        = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Memory request registers, owner and starvation streak
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            owner_q       <= OWNER_I;
            streak_q      <= '0;
            bus.m_req_o   <= 1'b0;
            bus.m_we_o    <= 1'b0;
            bus.m_addr_o  <= '0;
            bus.m_wdata_o <= '0;
            bus.m_wstrb_o <= '0;
        end else begin
            if (grant_d_c) begin
                owner_q       <= OWNER_D;
                bus.m_req_o   <= 1'b1;
                bus.m_we_o    <= bus.d_we_i;
                bus.m_addr_o  <= AW'(bus.d_addr_i);
                bus.m_wdata_o <= DW'(bus.d_wdata_i);
                bus.m_wstrb_o <= SW'(bus.d_wstrb_i);
                if (!bus.i_req_i) begin
                    streak_q <= '0;
                end else if (streak_q != STREAK_MAX) begin
                    streak_q <= streak_q + CW'(1);
                end
            end else if (grant_i_c) begin
                // Fetches are plain reads: no write data, no byte enables
                owner_q       <= OWNER_I;
                bus.m_req_o   <= 1'b1;
                bus.m_we_o    <= 1'b0;
                bus.m_addr_o  <= AW'(bus.i_addr_i);
                bus.m_wdata_o <= '0;
                bus.m_wstrb_o <= '0;
                streak_q      <= '0;
            end else if (state_q == REQ && bus.m_ready_i) begin
                bus.m_req_o <= 1'b0;
            end
        end
    end

    // Status flags
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            busy_o     <= 1'b0;
            spurious_o <= 1'b0;
        end else begin
            busy_o <= (state_d != IDLE);
            if (bus.m_rvalid_i && state_q != RESP) begin
                spurious_o <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter. A second instance with STARVE_LIMIT=0
// sees the same inputs and is checked for strict D priority.
module tb_mem_port_arbiter;

    logic clk;
    logic reset;
    logic busy_a, spur_a, busy_b, spur_b;
    int   n_cmp;
    int   n_err;
    logic [9:0] exp_i;

    mem_port_arbiter_if bus ();
    mem_port_arbiter_if bus_b ();

    assign bus_b.i_req_i    = bus.i_req_i;
    assign bus_b.i_addr_i   = bus.i_addr_i;
    assign bus_b.d_req_i    = bus.d_req_i;
    assign bus_b.d_we_i     = bus.d_we_i;
    assign bus_b.d_addr_i   = bus.d_addr_i;
    assign bus_b.d_wdata_i  = bus.d_wdata_i;
    assign bus_b.d_wstrb_i  = bus.d_wstrb_i;
    assign bus_b.m_ready_i  = bus.m_ready_i;
    assign bus_b.m_rvalid_i = bus.m_rvalid_i;
    assign bus_b.m_rdata_i  = bus.m_rdata_i;

    mem_port_arbiter #(.STARVE_LIMIT(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .bus        (bus.slave),
        .busy_o     (busy_a),
        .spurious_o (spur_a)
    );

    mem_port_arbiter #(.STARVE_LIMIT(0)) dut_strict (
        .clk        (clk),
        .reset      (reset),
        .bus        (bus_b.slave),
        .busy_o     (busy_b),
        .spurious_o (spur_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk1(input string tag, input logic obs, input logic exp_v);
        n_cmp++;
        assert (obs === exp_v) else begin
            n_err++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp_v);
        end
    endtask

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_cmp++;
        assert (obs === exp_v) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        exp_i = 10'b10_0001_0000;
        reset = 1'b0;
        bus.i_req_i    = 1'b0;
        bus.i_addr_i   = '0;
        bus.d_req_i    = 1'b0;
        bus.d_we_i     = 1'b0;
        bus.d_addr_i   = '0;
        bus.d_wdata_i  = '0;
        bus.d_wstrb_i  = '0;
        bus.m_ready_i  = 1'b0;
        bus.m_rvalid_i = 1'b0;
        bus.m_rdata_i  = '0;
        tick();
        tick();

        // Reset values
        chk1("rst_m_req", bus.m_req_o, 1'b0);
        chk32("rst_m_addr", bus.m_addr_o, 32'h0);
        chk1("rst_busy", busy_a, 1'b0);
        chk1("rst_spur", spur_a, 1'b0);
        reset = 1'b1;
        tick();

        // 1: single load
        bus.d_req_i  = 1'b1;
        bus.d_addr_i = 32'h100;
        bus.d_we_i   = 1'b0;
        settle();
        chk1("t1_d_ready", bus.d_ready_o, 1'b1);
        chk1("t1_i_ready", bus.i_ready_o, 1'b0);
        tick();
        bus.d_req_i = 1'b0;
        settle();
        chk1("t1_m_req", bus.m_req_o, 1'b1);
        chk32("t1_m_addr", bus.m_addr_o, 32'h100);
        chk1("t1_m_we", bus.m_we_o, 1'b0);
        chk1("t1_busy", busy_a, 1'b1);
        bus.m_ready_i = 1'b1;
        tick();
        bus.m_ready_i  = 1'b0;
        bus.m_rvalid_i = 1'b1;
        bus.m_rdata_i  = 32'hDEADBEEF;
        settle();
        chk1("t1_m_req_resp", bus.m_req_o, 1'b0);
        chk1("t1_d_rvalid", bus.d_rvalid_o, 1'b1);
        chk32("t1_d_rdata", bus.d_rdata_o, 32'hDEADBEEF);
        chk1("t1_i_rvalid", bus.i_rvalid_o, 1'b0);
        tick();
        bus.m_rvalid_i = 1'b0;
        settle();
        chk1("t1_busy_end", busy_a, 1'b0);
        chk1("t1_d_rvalid_end", bus.d_rvalid_o, 1'b0);
        chk1("t1_spur", spur_a, 1'b0);

        // 2: simultaneous requests, D first then I
        bus.i_req_i  = 1'b1;
        bus.i_addr_i = 32'h40;
        bus.d_req_i  = 1'b1;
        bus.d_addr_i = 32'h104;
        settle();
        chk1("t2_d_ready", bus.d_ready_o, 1'b1);
        chk1("t2_i_ready", bus.i_ready_o, 1'b0);
        tick();
        bus.d_req_i = 1'b0;
        settle();
        chk32("t2_m_addr_d", bus.m_addr_o, 32'h104);
        chk1("t2_i_ready_req", bus.i_ready_o, 1'b0);
        bus.m_ready_i = 1'b1;
        tick();
        bus.m_ready_i  = 1'b0;
        bus.m_rvalid_i = 1'b1;
        bus.m_rdata_i  = 32'h11;
        settle();
        chk1("t2_d_rvalid", bus.d_rvalid_o, 1'b1);
        chk1("t2_i_rvalid_d", bus.i_rvalid_o, 1'b0);
        tick();
        bus.m_rvalid_i = 1'b0;
        settle();
        chk1("t2_i_ready", bus.i_ready_o, 1'b1);
        chk1("t2_d_ready_i", bus.d_ready_o, 1'b0);
        tick();
        bus.i_req_i = 1'b0;
        settle();
        chk32("t2_m_addr_i", bus.m_addr_o, 32'h40);
        chk1("t2_m_we_i", bus.m_we_o, 1'b0);
        bus.m_ready_i = 1'b1;
        tick();
        bus.m_ready_i  = 1'b0;
        bus.m_rvalid_i = 1'b1;
        bus.m_rdata_i  = 32'h00000013;
        settle();
        chk1("t2_i_rvalid", bus.i_rvalid_o, 1'b1);
        chk32("t2_i_rdata", bus.i_rdata_o, 32'h00000013);
        chk1("t2_d_rvalid_i", bus.d_rvalid_o, 1'b0);
        tick();
        bus.m_rvalid_i = 1'b0;

        // 3: starvation, both requesters held high
        bus.i_req_i  = 1'b1;
        bus.d_req_i  = 1'b1;
        bus.d_we_i   = 1'b0;
        for (int k = 0; k < 10; k++) begin
            settle();
            chk1($sformatf("t3_i_ready_%0d", k), bus.i_ready_o, exp_i[k]);
            chk1($sformatf("t3_d_ready_%0d", k), bus.d_ready_o, ~exp_i[k]);
            chk1($sformatf("t3_strict_d_ready_%0d", k), bus_b.d_ready_o, 1'b1);
            chk1($sformatf("t3_strict_i_ready_%0d", k), bus_b.i_ready_o, 1'b0);
            tick();
            bus.m_ready_i = 1'b1;
            tick();
            bus.m_ready_i  = 1'b0;
            bus.m_rvalid_i = 1'b1;
            bus.m_rdata_i  = 32'(k);
            tick();
            bus.m_rvalid_i = 1'b0;
        end
        bus.i_req_i = 1'b0;
        bus.d_req_i = 1'b0;
        tick();

        // 4: store with memory backpressure
        bus.d_req_i   = 1'b1;
        bus.d_we_i    = 1'b1;
        bus.d_addr_i  = 32'h203;
        bus.d_wdata_i = 32'h5A5A5A5A;
        bus.d_wstrb_i = 4'b1000;
        settle();
        chk1("t4_d_ready", bus.d_ready_o, 1'b1);
        tick();
        bus.d_req_i   = 1'b0;
        bus.d_wdata_i = 32'h0;
        bus.d_wstrb_i = 4'b0000;
        for (int c = 0; c < 4; c++) begin
            settle();
            chk1($sformatf("t4_m_req_%0d", c), bus.m_req_o, 1'b1);
            chk1($sformatf("t4_m_we_%0d", c), bus.m_we_o, 1'b1);
            chk32($sformatf("t4_m_addr_%0d", c), bus.m_addr_o, 32'h203);
            chk32($sformatf("t4_m_wdata_%0d", c), bus.m_wdata_o, 32'h5A5A5A5A);
            chk32($sformatf("t4_m_wstrb_%0d", c), 32'(bus.m_wstrb_o), 32'h8);
            if (c == 3) bus.m_ready_i = 1'b1;
            tick();
        end
        bus.m_ready_i  = 1'b0;
        bus.m_rvalid_i = 1'b1;
        settle();
        chk1("t4_m_req_resp", bus.m_req_o, 1'b0);
        chk1("t4_d_rvalid", bus.d_rvalid_o, 1'b1);
        tick();
        bus.m_rvalid_i = 1'b0;
        settle();
        chk1("t4_d_rvalid_end", bus.d_rvalid_o, 1'b0);

        // 5: spurious response in IDLE, then reset during REQ
        bus.m_rvalid_i = 1'b1;
        settle();
        chk1("t5_d_rvalid_idle", bus.d_rvalid_o, 1'b0);
        chk1("t5_i_rvalid_idle", bus.i_rvalid_o, 1'b0);
        tick();
        bus.m_rvalid_i = 1'b0;
        settle();
        chk1("t5_spur_set", spur_a, 1'b1);
        tick();
        chk1("t5_spur_sticky", spur_a, 1'b1);
        bus.d_req_i  = 1'b1;
        bus.d_we_i   = 1'b1;
        bus.d_addr_i = 32'h300;
        bus.d_wdata_i = 32'h12345678;
        bus.d_wstrb_i = 4'b1111;
        tick();
        bus.d_req_i = 1'b0;
        settle();
        chk1("t5_m_req_before_rst", bus.m_req_o, 1'b1);
        reset = 1'b0;
        settle();
        chk1("t5_rst_m_req", bus.m_req_o, 1'b0);
        chk1("t5_rst_m_we", bus.m_we_o, 1'b0);
        chk32("t5_rst_m_addr", bus.m_addr_o, 32'h0);
        chk32("t5_rst_m_wdata", bus.m_wdata_o, 32'h0);
        chk32("t5_rst_m_wstrb", 32'(bus.m_wstrb_o), 32'h0);
        chk1("t5_rst_busy", busy_a, 1'b0);
        chk1("t5_rst_spur", spur_a, 1'b0);
        chk1("t5_rst_d_ready", bus.d_ready_o, 1'b0);
        tick();
        reset = 1'b1;
        bus.m_rvalid_i = 1'b1;
        settle();
        chk1("t5_late_d_rvalid", bus.d_rvalid_o, 1'b0);
        tick();
        bus.m_rvalid_i = 1'b0;
        settle();
        chk1("t5_late_spur", spur_a, 1'b1);
        chk1("t5_late_busy", busy_a, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
